// File: rtl/ysyx_24100029_bpu_pkg.sv
// Shared types for the BPU update controller: branch type codes, FSM states, update record.
package ysyx_24100029_bpu_pkg;

  localparam logic [1:0] BR_TYPE_PLAIN = 2'b00;
  localparam logic [1:0] BR_TYPE_CALL  = 2'b01;
  localparam logic [1:0] BR_TYPE_RET   = 2'b10;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } upd_state_e;

  // One resolved-branch record as buffered between execute and the BPU commit port.
  typedef struct packed {
    logic        is_taken;
    logic [31:0] pc;
    logic [1:0]  pc_type;
    logic [31:0] npc;
    logic        mispred;
  } br_upd_t;

endpackage : ysyx_24100029_bpu_pkg

// File: rtl/ysyx_24100029_bpu_upd_fifo.sv
// Synchronous FIFO of update records; head is visible combinationally from storage.
module ysyx_24100029_bpu_upd_fifo
  import ysyx_24100029_bpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  br_upd_t                  push_data,
  input  logic                     pop,
  output br_upd_t                  head_c,
  output logic                     full_c,
  output logic [$clog2(DEPTH):0]   count_q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  br_upd_t          mem_q [DEPTH];
  br_upd_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign full_c = (count_q == CNT_W'(DEPTH));
  assign head_c = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; guards ignore push-when-full / pop-when-empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & ~full_c;
    do_pop   = pop & (count_q != '0);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the commit fields read zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : ysyx_24100029_bpu_upd_fifo

// File: rtl/ysyx_24100029_bpu_upd_ctrl.sv
// BPU update scheduler: buffers resolved branches, replays them to the BPU, and sweeps tables.
module ysyx_24100029_bpu_upd_ctrl
  import ysyx_24100029_bpu_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned SWEEP_IDX_WIDTH = 5,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic                       ex_is_taken,
  input  logic [31:0]                ex_pc,
  input  logic [1:0]                 ex_pc_type,
  input  logic [31:0]                ex_npc,
  input  logic                       ex_mispred,
  input  logic                       hold,
  input  logic                       sweep_req,
  output logic                       br_valid,
  output logic                       br_is_taken,
  output logic [31:0]                br_pc,
  output logic [1:0]                 br_pc_type,
  output logic [31:0]                br_npc,
  output logic                       sweep_en,
  output logic [SWEEP_IDX_WIDTH-1:0] sweep_idx,
  output logic                       bpu_busy,
  output logic [CNT_WIDTH-1:0]       upd_cnt,
  output logic [CNT_WIDTH-1:0]       mispred_cnt
);

  localparam int unsigned FIFO_CNT_W = $clog2(DEPTH) + 1;

  upd_state_e                 state_q, state_d;
  logic [SWEEP_IDX_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
  logic [CNT_WIDTH-1:0]       upd_cnt_q, upd_cnt_d;
  logic [CNT_WIDTH-1:0]       mispred_cnt_q, mispred_cnt_d;

  br_upd_t                    push_rec;
  br_upd_t                    head_rec;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [FIFO_CNT_W-1:0]      fifo_count;
  logic                       push;
  logic                       pop;

  assign push_rec = '{is_taken: ex_is_taken, pc: ex_pc, pc_type: ex_pc_type,
                      npc: ex_npc, mispred: ex_mispred};
  assign fifo_empty = (fifo_count == '0);
  assign push       = ex_valid & ex_ready;
  assign pop        = br_valid;

  ysyx_24100029_bpu_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head_c    (head_rec),
    .full_c    (fifo_full),
    .count_q   (fifo_count)
  );

  assign br_is_taken = head_rec.is_taken;
  assign br_pc       = head_rec.pc;
  assign br_pc_type  = head_rec.pc_type;
  assign br_npc      = head_rec.npc;
  assign sweep_idx   = sweep_idx_q;
  assign upd_cnt     = upd_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // FSM next-state and handshake outputs; everything here depends on registers plus hold/sweep_req.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = '0;
    ex_ready    = 1'b0;
    br_valid    = 1'b0;
    sweep_en    = 1'b0;
    bpu_busy    = 1'b1;
    case (state_q)
      INIT: begin
        sweep_en    = 1'b1;
        sweep_idx_d = sweep_idx_q + SWEEP_IDX_WIDTH'(1);
        if (&sweep_idx_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        bpu_busy = 1'b0;
        ex_ready = ~fifo_full;
        br_valid = ~fifo_empty & ~hold;
        if (sweep_req) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        br_valid = ~fifo_empty & ~hold;
        if (fifo_empty) begin
          state_d = INIT;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Saturating statistics over issued updates.
  always_comb begin
    upd_cnt_d     = upd_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (pop) begin
      if (upd_cnt_q != '1) begin
        upd_cnt_d = upd_cnt_q + CNT_WIDTH'(1);
      end
      if (head_rec.mispred && (mispred_cnt_q != '1)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State, sweep index and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= INIT;
      sweep_idx_q   <= '0;
      upd_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      upd_cnt_q     <= upd_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule : ysyx_24100029_bpu_upd_ctrl

// File: tb/tb_ysyx_24100029_bpu_upd_ctrl.sv
// Directed self-checking bench for the BPU update controller.
module tb_ysyx_24100029_bpu_upd_ctrl;
  import ysyx_24100029_bpu_pkg::*;

  localparam int unsigned SW = 5;
  localparam int unsigned CW = 32;

  logic          clock;
  logic          reset;
  logic          ex_valid;
  logic          ex_ready;
  logic          ex_is_taken;
  logic [31:0]   ex_pc;
  logic [1:0]    ex_pc_type;
  logic [31:0]   ex_npc;
  logic          ex_mispred;
  logic          hold;
  logic          sweep_req;
  logic          br_valid;
  logic          br_is_taken;
  logic [31:0]   br_pc;
  logic [1:0]    br_pc_type;
  logic [31:0]   br_npc;
  logic          sweep_en;
  logic [SW-1:0] sweep_idx;
  logic          bpu_busy;
  logic [CW-1:0] upd_cnt;
  logic [CW-1:0] mispred_cnt;

  int errors = 0;
  int checks = 0;
  int exp_upd = 0;
  int exp_mis = 0;

  ysyx_24100029_bpu_upd_ctrl #(
    .DEPTH           (4),
    .SWEEP_IDX_WIDTH (SW),
    .CNT_WIDTH       (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_is_taken (ex_is_taken),
    .ex_pc       (ex_pc),
    .ex_pc_type  (ex_pc_type),
    .ex_npc      (ex_npc),
    .ex_mispred  (ex_mispred),
    .hold        (hold),
    .sweep_req   (sweep_req),
    .br_valid    (br_valid),
    .br_is_taken (br_is_taken),
    .br_pc       (br_pc),
    .br_pc_type  (br_pc_type),
    .br_npc      (br_npc),
    .sweep_en    (sweep_en),
    .sweep_idx   (sweep_idx),
    .bpu_busy    (bpu_busy),
    .upd_cnt     (upd_cnt),
    .mispred_cnt (mispred_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic br_upd_t mk_rec(input int i);
    br_upd_t r;
    r.is_taken = ((i % 2) == 1);
    r.pc       = 32'h8000_2000 + 32'(i) * 32'd16;
    r.pc_type  = 2'(i % 3);
    r.npc      = 32'h9000_0000 + 32'(i) * 32'd4;
    r.mispred  = ((i % 3) == 2);
    return r;
  endfunction

  task automatic drive(input br_upd_t r);
    ex_is_taken = r.is_taken;
    ex_pc       = r.pc;
    ex_pc_type  = r.pc_type;
    ex_npc      = r.npc;
    ex_mispred  = r.mispred;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ex_valid = 1'b1;
    drive(mk_rec(1));
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (sweep_en !== 1'b1 || bpu_busy !== 1'b1 || sweep_idx !== '0) begin
      errors++;
      $display("FAIL reset_sweep: sweep_en=%b busy=%b idx=%0d, want 1 1 0", sweep_en, bpu_busy, sweep_idx);
    end
    checks++;
    if (ex_ready !== 1'b0 || br_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: ex_ready=%b br_valid=%b, want 0 0", ex_ready, br_valid);
    end
    checks++;
    if (br_pc !== 32'd0 || br_npc !== 32'd0 || br_pc_type !== 2'd0 || br_is_taken !== 1'b0) begin
      errors++;
      $display("FAIL reset_fields: pc=%h npc=%h type=%b tk=%b, want zeros", br_pc, br_npc, br_pc_type, br_is_taken);
    end
    checks++;
    if (upd_cnt !== '0 || mispred_cnt !== '0) begin
      errors++;
      $display("FAIL reset_counters: upd=%0d mis=%0d, want 0 0", upd_cnt, mispred_cnt);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      checks++;
      if (sweep_en !== 1'b1 || sweep_idx !== SW'(c)) begin
        errors++;
        $display("FAIL init_sweep c%0d: sweep_en=%b idx=%0d, want 1 %0d", c, sweep_en, sweep_idx, c);
      end
      checks++;
      if (ex_ready !== 1'b0 || br_valid !== 1'b0) begin
        errors++;
        $display("FAIL init_blocked c%0d: ex_ready=%b br_valid=%b, want 0 0", c, ex_ready, br_valid);
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (ex_ready !== 1'b1 || sweep_en !== 1'b0 || bpu_busy !== 1'b0 || sweep_idx !== '0) begin
      errors++;
      $display("FAIL run_entry: ex_ready=%b sweep_en=%b busy=%b idx=%0d, want 1 0 0 0",
               ex_ready, sweep_en, bpu_busy, sweep_idx);
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_single();
    br_upd_t r;
    r.is_taken = 1'b1;
    r.pc       = 32'h8000_0010;
    r.pc_type  = BR_TYPE_CALL;
    r.npc      = 32'h8000_0100;
    r.mispred  = 1'b0;
    @(negedge clock);
    ex_valid = 1'b1;
    drive(r);
    #1;
    checks++;
    if (ex_ready !== 1'b1 || br_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_push: ex_ready=%b br_valid=%b, want 1 0 (no bypass)", ex_ready, br_valid);
    end
    @(negedge clock);
    ex_valid = 1'b0;
    #1;
    checks++;
    if (br_valid !== 1'b1 || br_pc !== 32'h8000_0010 || br_npc !== 32'h8000_0100 ||
        br_pc_type !== 2'b01 || br_is_taken !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: v=%b pc=%h npc=%h type=%b tk=%b, want 1 80000010 80000100 01 1",
               br_valid, br_pc, br_npc, br_pc_type, br_is_taken);
    end
    exp_upd++;
    @(negedge clock);
    #1;
    checks++;
    if (br_valid !== 1'b0 || upd_cnt !== CW'(exp_upd) || mispred_cnt !== CW'(exp_mis)) begin
      errors++;
      $display("FAIL single_count: v=%b upd=%0d mis=%0d, want 0 %0d %0d",
               br_valid, upd_cnt, mispred_cnt, exp_upd, exp_mis);
    end
  endtask

  task automatic test_hold();
    br_upd_t r;
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      ex_valid = 1'b1;
      drive(mk_rec(10 + i));
      #1;
      checks++;
      if (ex_ready !== (i < 4) || br_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_fill i%0d: ex_ready=%b br_valid=%b, want %b 0", i, ex_ready, br_valid, (i < 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i == 0) begin
        ex_valid = 1'b0;
        hold     = 1'b0;
      end
      #1;
      r = mk_rec(10 + i);
      checks++;
      if (br_valid !== 1'b1 || br_pc !== r.pc || br_npc !== r.npc || br_pc_type !== r.pc_type ||
          br_is_taken !== r.is_taken) begin
        errors++;
        $display("FAIL hold_issue i%0d: v=%b pc=%h npc=%h, want 1 %h %h", i, br_valid, br_pc, br_npc, r.pc, r.npc);
      end
      checks++;
      if (ex_ready !== (i != 0)) begin
        errors++;
        $display("FAIL hold_ready i%0d: ex_ready=%b, want %b", i, ex_ready, (i != 0));
      end
      exp_upd++;
      if (r.mispred) exp_mis++;
    end
    @(negedge clock);
    #1;
    checks++;
    if (br_valid !== 1'b0 || upd_cnt !== CW'(exp_upd) || mispred_cnt !== CW'(exp_mis)) begin
      errors++;
      $display("FAIL hold_count: v=%b upd=%0d mis=%0d, want 0 %0d %0d",
               br_valid, upd_cnt, mispred_cnt, exp_upd, exp_mis);
    end
  endtask

  task automatic test_back_to_back();
    br_upd_t q[$];
    br_upd_t h;
    int      nxt;
    logic    exp_ready;
    logic    exp_valid;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      ex_valid = 1'b1;
      drive(mk_rec(20 + i));
      #1;
      checks++;
      if (ex_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_fill i%0d: ex_ready=%b, want 1", i, ex_ready);
      end
      q.push_back(mk_rec(20 + i));
    end
    nxt = 24;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      hold = 1'b0;
      if (c < 6) begin
        ex_valid = 1'b1;
        drive(mk_rec(nxt));
      end else begin
        ex_valid = 1'b0;
      end
      #1;
      exp_ready = (q.size() < 4);
      exp_valid = (q.size() > 0);
      checks++;
      if (ex_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_ready c%0d: ex_ready=%b, want %b", c, ex_ready, exp_ready);
      end
      checks++;
      if (br_valid !== exp_valid) begin
        errors++;
        $display("FAIL b2b_valid c%0d: br_valid=%b, want %b", c, br_valid, exp_valid);
      end
      if (exp_valid) begin
        h = q.pop_front();
        checks++;
        if (br_pc !== h.pc || br_npc !== h.npc || br_pc_type !== h.pc_type || br_is_taken !== h.is_taken) begin
          errors++;
          $display("FAIL b2b_head c%0d: pc=%h npc=%h, want %h %h", c, br_pc, br_npc, h.pc, h.npc);
        end
        exp_upd++;
        if (h.mispred) exp_mis++;
      end
      if (exp_ready && ex_valid) begin
        q.push_back(mk_rec(nxt));
        nxt++;
      end
    end
    checks++;
    if (upd_cnt !== CW'(exp_upd) || mispred_cnt !== CW'(exp_mis)) begin
      errors++;
      $display("FAIL b2b_count: upd=%0d mis=%0d, want %0d %0d", upd_cnt, mispred_cnt, exp_upd, exp_mis);
    end
  endtask

  task automatic test_sweep_req();
    br_upd_t r;
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      ex_valid = 1'b1;
      drive(mk_rec(40 + i));
    end
    @(negedge clock);
    ex_valid  = 1'b0;
    hold      = 1'b0;
    sweep_req = 1'b1;
    #1;
    r = mk_rec(40);
    checks++;
    if (br_valid !== 1'b1 || br_pc !== r.pc || bpu_busy !== 1'b0) begin
      errors++;
      $display("FAIL sweep_first: v=%b pc=%h busy=%b, want 1 %h 0", br_valid, br_pc, bpu_busy, r.pc);
    end
    exp_upd++;
    if (r.mispred) exp_mis++;
    @(negedge clock);
    sweep_req = 1'b0;
    #1;
    r = mk_rec(41);
    checks++;
    if (br_valid !== 1'b1 || br_pc !== r.pc || bpu_busy !== 1'b1 || ex_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_second: v=%b pc=%h busy=%b rdy=%b, want 1 %h 1 0", br_valid, br_pc, bpu_busy, ex_ready, r.pc);
    end
    exp_upd++;
    if (r.mispred) exp_mis++;
    @(negedge clock);
    ex_valid = 1'b1;
    drive(mk_rec(42));
    #1;
    checks++;
    if (br_valid !== 1'b0 || bpu_busy !== 1'b1 || sweep_en !== 1'b0 || ex_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: v=%b busy=%b sweep_en=%b rdy=%b, want 0 1 0 0", br_valid, bpu_busy, sweep_en, ex_ready);
    end
    for (int c = 0; c < 32; c++) begin
      @(negedge clock);
      sweep_req = (c < 31);
      #1;
      checks++;
      if (sweep_en !== 1'b1 || sweep_idx !== SW'(c) || bpu_busy !== 1'b1) begin
        errors++;
        $display("FAIL resweep c%0d: sweep_en=%b idx=%0d busy=%b, want 1 %0d 1", c, sweep_en, sweep_idx, bpu_busy, c);
      end
      checks++;
      if (ex_ready !== 1'b0 || br_valid !== 1'b0) begin
        errors++;
        $display("FAIL resweep_blocked c%0d: ex_ready=%b br_valid=%b, want 0 0", c, ex_ready, br_valid);
      end
    end
    @(negedge clock);
    sweep_req = 1'b0;
    #1;
    checks++;
    if (ex_ready !== 1'b1 || sweep_en !== 1'b0 || bpu_busy !== 1'b0) begin
      errors++;
      $display("FAIL resweep_done: rdy=%b sweep_en=%b busy=%b, want 1 0 0", ex_ready, sweep_en, bpu_busy);
    end
    ex_valid = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (br_valid !== 1'b0 || upd_cnt !== CW'(exp_upd) || mispred_cnt !== CW'(exp_mis)) begin
      errors++;
      $display("FAIL sweep_count: v=%b upd=%0d mis=%0d, want 0 %0d %0d", br_valid, upd_cnt, mispred_cnt, exp_upd, exp_mis);
    end
  endtask

  task automatic test_reset_mid();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      ex_valid = 1'b1;
      drive(mk_rec(50 + i));
    end
    @(negedge clock);
    ex_valid  = 1'b0;
    sweep_req = 1'b1;
    #1;
    checks++;
    if (bpu_busy !== 1'b0 || br_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_run: busy=%b v=%b, want 0 0", bpu_busy, br_valid);
    end
    @(negedge clock);
    sweep_req = 1'b0;
    #1;
    checks++;
    if (bpu_busy !== 1'b1 || br_valid !== 1'b0 || sweep_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain: busy=%b v=%b sweep_en=%b, want 1 0 0", bpu_busy, br_valid, sweep_en);
    end
    #2;
    reset = 1'b0;
    hold  = 1'b0;
    #1;
    checks++;
    if (br_valid !== 1'b0 || upd_cnt !== '0 || mispred_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset: v=%b upd=%0d mis=%0d, want 0 0 0", br_valid, upd_cnt, mispred_cnt);
    end
    checks++;
    if (sweep_en !== 1'b1 || sweep_idx !== '0 || ex_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_sweep: sweep_en=%b idx=%0d rdy=%b, want 1 0 0", sweep_en, sweep_idx, ex_ready);
    end
    exp_upd = 0;
    exp_mis = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clock);
      #1;
      checks++;
      if (sweep_en !== 1'b1 || sweep_idx !== SW'(c) || br_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_resweep c%0d: sweep_en=%b idx=%0d v=%b, want 1 %0d 0", c, sweep_en, sweep_idx, br_valid, c);
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (ex_ready !== 1'b1 || br_valid !== 1'b0 || upd_cnt !== '0) begin
      errors++;
      $display("FAIL mid_after: rdy=%b v=%b upd=%0d, want 1 0 0", ex_ready, br_valid, upd_cnt);
    end
  endtask

  initial begin
    ex_valid    = 1'b0;
    ex_is_taken = 1'b0;
    ex_pc       = '0;
    ex_pc_type  = '0;
    ex_npc      = '0;
    ex_mispred  = 1'b0;
    hold        = 1'b0;
    sweep_req   = 1'b0;
    reset       = 1'b0;
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_sweep_req();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_ysyx_24100029_bpu_upd_ctrl
